// File: rtl/pio_engine.sv
// Single programmable-I/O execution engine: 32x16 instruction memory, one
// shift/execute state machine with 4-deep TX/RX FIFOs, and a 4-slot pad arbitrator.
module pio_engine (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] gpio_input,
    input  logic [15:0] instr_in,
    input  logic [4:0]  write_addr,
    input  logic        write_en,
    input  logic        push_en,
    input  logic [31:0] fifo_in,
    input  logic        pop_en,
    output logic [31:0] fifo_out,
    input  logic        out_shiftdir,
    output logic [4:0]  pc,
    output logic [31:0] core_output,
    output logic [31:0] core_drive
);
    typedef enum logic [0:0] {ST_EXEC = 1'b0, ST_DELAY = 1'b1} state_t;

    localparam logic [2:0] OP_JMP = 3'b000;
    localparam logic [2:0] OP_IN  = 3'b010;
    localparam logic [2:0] OP_OUT = 3'b011;
    localparam logic [2:0] OP_PSH = 3'b100;
    localparam logic [2:0] OP_MOV = 3'b101;
    localparam logic [2:0] OP_SET = 3'b111;

    function automatic logic [31:0] lo_mask(input logic [5:0] n);
        logic [31:0] m;
        if (n >= 6'd32) m = 32'hFFFF_FFFF;
        else            m = (32'd1 << n) - 32'd1;
        return m;
    endfunction

    function automatic logic [5:0] sat_add(input logic [5:0] a, input logic [5:0] b);
        logic [6:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > 7'd32) ? 6'd32 : s[5:0];
    endfunction

    logic [15:0] imem_r [32];
    state_t      state_r;
    logic [4:0]  pc_r, pend_pc_r, delay_r;
    logic [31:0] x_r, y_r, isr_r, osr_r, pin_out_r, pin_dir_r;
    logic [5:0]  isr_cnt_r, osr_cnt_r;
    logic [31:0] tx_mem_r [4];
    logic [31:0] rx_mem_r [4];
    logic [1:0]  tx_rd_r, tx_wr_r, rx_rd_r, rx_wr_r;
    logic [2:0]  tx_cnt_r, rx_cnt_r;

    logic [15:0] instr_s;
    logic [5:0]  cnt_s;
    logic [31:0] mask_s, out_val_s, osr_sh_s, src_s;
    logic        src_ok_s, taken_s, stall_s, pull_req_s, push_req_s, fire_s;
    logic [31:0] x_nxt_s, y_nxt_s, isr_nxt_s, osr_nxt_s, pout_nxt_s, pdir_nxt_s;
    logic [5:0]  isr_cnt_nxt_s, osr_cnt_nxt_s;
    logic [4:0]  next_pc_s;
    logic        tx_push_s, tx_pull_s, rx_push_s, rx_pop_s;
    logic [31:0] slot_out_s [4];
    logic [31:0] slot_drv_s [4];
    logic [31:0] core_output_s, core_drive_s;

    // Decode and execute the instruction at pc; results are committed only when fire_s
    always_comb begin
        instr_s       = imem_r[pc_r];
        cnt_s         = (instr_s[4:0] == 5'd0) ? 6'd32 : {1'b0, instr_s[4:0]};
        mask_s        = lo_mask(cnt_s);
        x_nxt_s       = x_r;
        y_nxt_s       = y_r;
        isr_nxt_s     = isr_r;
        isr_cnt_nxt_s = isr_cnt_r;
        osr_nxt_s     = osr_r;
        osr_cnt_nxt_s = osr_cnt_r;
        pout_nxt_s    = pin_out_r;
        pdir_nxt_s    = pin_dir_r;
        taken_s       = 1'b0;
        stall_s       = 1'b0;
        pull_req_s    = 1'b0;
        push_req_s    = 1'b0;
        src_s         = 32'd0;
        src_ok_s      = 1'b0;
        if (out_shiftdir) begin
            out_val_s = osr_r & mask_s;
            osr_sh_s  = osr_r >> cnt_s;
        end else begin
            out_val_s = osr_r >> (6'd32 - cnt_s);
            osr_sh_s  = osr_r << cnt_s;
        end
        case (instr_s[15:13])
            OP_JMP: begin
                case (instr_s[7:5])
                    3'd0: taken_s = 1'b1;
                    3'd1: taken_s = (x_r == 32'd0);
                    3'd2: begin
                        taken_s = (x_r != 32'd0);
                        x_nxt_s = x_r - 32'd1;
                    end
                    3'd3: taken_s = (y_r == 32'd0);
                    3'd4: begin
                        taken_s = (y_r != 32'd0);
                        y_nxt_s = y_r - 32'd1;
                    end
                    3'd5: taken_s = (x_r != y_r);
                    3'd6: taken_s = gpio_input[0];
                    default: taken_s = (osr_cnt_r < 6'd32);
                endcase
            end
            OP_IN: begin
                case (instr_s[7:5])
                    3'd0:    begin src_s = gpio_input; src_ok_s = 1'b1; end
                    3'd1:    begin src_s = x_r;        src_ok_s = 1'b1; end
                    3'd2:    begin src_s = y_r;        src_ok_s = 1'b1; end
                    3'd3:    begin src_s = 32'd0;      src_ok_s = 1'b1; end
                    default: begin src_s = 32'd0;      src_ok_s = 1'b0; end
                endcase
                if (src_ok_s) begin
                    isr_nxt_s     = (isr_r << cnt_s) | (src_s & mask_s);
                    isr_cnt_nxt_s = sat_add(isr_cnt_r, cnt_s);
                end else begin
                    isr_nxt_s     = isr_r;
                    isr_cnt_nxt_s = isr_cnt_r;
                end
            end
            OP_OUT: begin
                case (instr_s[7:5])
                    3'd0:    pout_nxt_s = (pin_out_r & ~mask_s) | (out_val_s & mask_s);
                    3'd1:    x_nxt_s = out_val_s;
                    3'd2:    y_nxt_s = out_val_s;
                    3'd4:    pdir_nxt_s = (pin_dir_r & ~mask_s) | (out_val_s & mask_s);
                    default: pout_nxt_s = pin_out_r;
                endcase
                // Undefined destinations leave the OSR untouched
                if (instr_s[7:5] <= 3'd4) begin
                    osr_nxt_s     = osr_sh_s;
                    osr_cnt_nxt_s = sat_add(osr_cnt_r, cnt_s);
                end else begin
                    osr_nxt_s     = osr_r;
                    osr_cnt_nxt_s = osr_cnt_r;
                end
            end
            OP_PSH: begin
                if (!instr_s[7]) begin
                    if (rx_cnt_r != 3'd4) begin
                        push_req_s    = 1'b1;
                        isr_nxt_s     = 32'd0;
                        isr_cnt_nxt_s = 6'd0;
                    end else begin
                        stall_s = instr_s[5];
                    end
                end else begin
                    if (tx_cnt_r != 3'd0) begin
                        pull_req_s    = 1'b1;
                        osr_nxt_s     = tx_mem_r[tx_rd_r];
                        osr_cnt_nxt_s = 6'd0;
                    end else begin
                        stall_s = instr_s[5];
                    end
                end
            end
            OP_MOV: begin
                case (instr_s[2:0])
                    3'd0:    begin src_s = gpio_input; src_ok_s = 1'b1; end
                    3'd1:    begin src_s = x_r;        src_ok_s = 1'b1; end
                    3'd2:    begin src_s = y_r;        src_ok_s = 1'b1; end
                    3'd3:    begin src_s = 32'd0;      src_ok_s = 1'b1; end
                    3'd6:    begin src_s = isr_r;      src_ok_s = 1'b1; end
                    3'd7:    begin src_s = osr_r;      src_ok_s = 1'b1; end
                    default: begin src_s = 32'd0;      src_ok_s = 1'b0; end
                endcase
                if (src_ok_s) begin
                    case (instr_s[7:5])
                        3'd0:    pout_nxt_s = src_s;
                        3'd1:    x_nxt_s = src_s;
                        3'd2:    y_nxt_s = src_s;
                        default: pout_nxt_s = pin_out_r;
                    endcase
                end else begin
                    pout_nxt_s = pin_out_r;
                end
            end
            OP_SET: begin
                case (instr_s[7:5])
                    3'd0:    pout_nxt_s = {pin_out_r[31:5], instr_s[4:0]};
                    3'd1:    x_nxt_s = {27'd0, instr_s[4:0]};
                    3'd2:    y_nxt_s = {27'd0, instr_s[4:0]};
                    3'd4:    pdir_nxt_s = {pin_dir_r[31:5], instr_s[4:0]};
                    default: pout_nxt_s = pin_out_r;
                endcase
            end
            default: taken_s = 1'b0;
        endcase
        next_pc_s = taken_s ? instr_s[4:0] : pc_r + 5'd1;
    end

    assign fire_s    = (state_r == ST_EXEC) && !stall_s;
    assign tx_push_s = push_en && (tx_cnt_r != 3'd4);
    assign tx_pull_s = fire_s && pull_req_s;
    assign rx_push_s = fire_s && push_req_s;
    assign rx_pop_s  = pop_en && (rx_cnt_r != 3'd0);

    // Instruction memory: synchronous write, cleared to JMP-always-0 on reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) imem_r[i] <= 16'h0000;
        end else if (write_en) begin
            imem_r[write_addr] <= instr_in;
        end
    end

    // Execution state machine: one execute cycle, then optional delay cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= ST_EXEC;
            pc_r      <= 5'd0;
            pend_pc_r <= 5'd0;
            delay_r   <= 5'd0;
            x_r       <= 32'd0;
            y_r       <= 32'd0;
            isr_r     <= 32'd0;
            osr_r     <= 32'd0;
            isr_cnt_r <= 6'd0;
            osr_cnt_r <= 6'd32;
            pin_out_r <= 32'd0;
            pin_dir_r <= 32'd0;
        end else begin
            case (state_r)
                ST_EXEC: begin
                    if (fire_s) begin
                        x_r       <= x_nxt_s;
                        y_r       <= y_nxt_s;
                        isr_r     <= isr_nxt_s;
                        osr_r     <= osr_nxt_s;
                        isr_cnt_r <= isr_cnt_nxt_s;
                        osr_cnt_r <= osr_cnt_nxt_s;
                        pin_out_r <= pout_nxt_s;
                        pin_dir_r <= pdir_nxt_s;
                        if (instr_s[12:8] == 5'd0) begin
                            pc_r <= next_pc_s;
                        end else begin
                            delay_r   <= instr_s[12:8];
                            pend_pc_r <= next_pc_s;
                            state_r   <= ST_DELAY;
                        end
                    end
                end
                ST_DELAY: begin
                    delay_r <= delay_r - 5'd1;
                    if (delay_r == 5'd1) begin
                        pc_r    <= pend_pc_r;
                        state_r <= ST_EXEC;
                    end
                end
                default: state_r <= ST_EXEC;
            endcase
        end
    end

    // TX FIFO: host pushes, FSM PULL pops
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) tx_mem_r[i] <= 32'd0;
            tx_rd_r  <= 2'd0;
            tx_wr_r  <= 2'd0;
            tx_cnt_r <= 3'd0;
        end else begin
            if (tx_push_s) begin
                tx_mem_r[tx_wr_r] <= fifo_in;
                tx_wr_r           <= tx_wr_r + 2'd1;
            end
            if (tx_pull_s) tx_rd_r <= tx_rd_r + 2'd1;
            tx_cnt_r <= tx_cnt_r + {2'd0, tx_push_s} - {2'd0, tx_pull_s};
        end
    end

    // RX FIFO: FSM PUSH fills, host pops
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) rx_mem_r[i] <= 32'd0;
            rx_rd_r  <= 2'd0;
            rx_wr_r  <= 2'd0;
            rx_cnt_r <= 3'd0;
        end else begin
            if (rx_push_s) begin
                rx_mem_r[rx_wr_r] <= isr_r;
                rx_wr_r           <= rx_wr_r + 2'd1;
            end
            if (rx_pop_s) rx_rd_r <= rx_rd_r + 2'd1;
            rx_cnt_r <= rx_cnt_r + {2'd0, rx_push_s} - {2'd0, rx_pop_s};
        end
    end

    assign slot_out_s[0] = pin_out_r;
    assign slot_drv_s[0] = pin_dir_r;
    assign slot_out_s[1] = 32'd0;
    assign slot_drv_s[1] = 32'd0;
    assign slot_out_s[2] = 32'd0;
    assign slot_drv_s[2] = 32'd0;
    assign slot_out_s[3] = 32'd0;
    assign slot_drv_s[3] = 32'd0;

    // Pad arbitration: highest-index driving slot owns each bit
    always_comb begin
        core_output_s = 32'd0;
        core_drive_s  = 32'd0;
        for (int b = 0; b < 32; b++) begin
            for (int s = 0; s < 4; s++) begin
                if (slot_drv_s[s][b]) begin
                    core_output_s[b] = slot_out_s[s][b];
                    core_drive_s[b]  = 1'b1;
                end else begin
                    core_output_s[b] = core_output_s[b];
                    core_drive_s[b]  = core_drive_s[b];
                end
            end
        end
    end

    assign core_output = core_output_s;
    assign core_drive  = core_drive_s;
    assign pc          = pc_r;
    assign fifo_out    = (rx_cnt_r == 3'd0) ? 32'd0 : rx_mem_r[rx_rd_r];

endmodule

// File: tb/tb_pio_engine.sv
// Bench for pio_engine: directed programs with literal expectations plus random
// programs and traffic, all cross-checked every cycle against a queue-based model.
module tb_pio_engine;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] gpio_input = 32'd0;
    logic [15:0] instr_in = 16'd0;
    logic [4:0]  write_addr = 5'd0;
    logic        write_en = 1'b0;
    logic        push_en = 1'b0;
    logic [31:0] fifo_in = 32'd0;
    logic        pop_en = 1'b0;
    logic        out_shiftdir = 1'b0;
    logic [31:0] fifo_out, core_output, core_drive;
    logic [4:0]  pc;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    pio_engine dut (
        .clk(clk), .rst(rst), .gpio_input(gpio_input), .instr_in(instr_in),
        .write_addr(write_addr), .write_en(write_en), .push_en(push_en),
        .fifo_in(fifo_in), .pop_en(pop_en), .fifo_out(fifo_out),
        .out_shiftdir(out_shiftdir), .pc(pc), .core_output(core_output),
        .core_drive(core_drive)
    );

    // ---------------- behavioural model ----------------
    logic [15:0] m_imem [32];
    logic [4:0]  m_pc, m_pend;
    int          m_delay;
    logic [31:0] m_x, m_y, m_isr, m_osr, m_pout, m_pdir;
    int          m_isrc, m_osrc;
    logic [31:0] m_tx[$];
    logic [31:0] m_rx[$];

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_imem[i] = 16'h0000;
        m_pc = 5'd0; m_pend = 5'd0; m_delay = 0;
        m_x = 32'd0; m_y = 32'd0; m_isr = 32'd0; m_osr = 32'd0;
        m_isrc = 0; m_osrc = 32; m_pout = 32'd0; m_pdir = 32'd0;
        m_tx.delete(); m_rx.delete();
    endtask

    task automatic model_step();
        logic [15:0] ins;
        logic [31:0] val, msk, pushed;
        int op, sel, n, dly, tx0, rx0;
        bit stall, taken, ok, fsm_pull, fsm_push;
        logic [4:0] nxt;
        tx0 = m_tx.size(); rx0 = m_rx.size();
        ins = m_imem[m_pc];
        if (write_en) m_imem[write_addr] = instr_in;
        stall = 0; fsm_pull = 0; fsm_push = 0; pushed = 32'd0;
        if (m_delay > 0) begin
            m_delay--;
            if (m_delay == 0) m_pc = m_pend;
        end else begin
            op = int'(ins[15:13]); sel = int'(ins[7:5]); dly = int'(ins[12:8]);
            n = (ins[4:0] == 5'd0) ? 32 : int'(ins[4:0]);
            msk = (n == 32) ? 32'hFFFF_FFFF : ((32'd1 << n) - 32'd1);
            taken = 0;
            case (op)
                0: case (sel)
                    0: taken = 1;
                    1: taken = (m_x == 0);
                    2: begin taken = (m_x != 0); m_x = m_x - 1; end
                    3: taken = (m_y == 0);
                    4: begin taken = (m_y != 0); m_y = m_y - 1; end
                    5: taken = (m_x != m_y);
                    6: taken = gpio_input[0];
                    default: taken = (m_osrc < 32);
                endcase
                2: begin
                    ok = 1;
                    case (sel) 0: val = gpio_input; 1: val = m_x; 2: val = m_y; 3: val = 0;
                        default: begin ok = 0; val = 0; end endcase
                    if (ok) begin
                        m_isr = (n == 32) ? val : ((m_isr << n) | (val & msk));
                        m_isrc = imin(m_isrc + n, 32);
                    end
                end
                3: if (sel <= 4) begin
                    if (out_shiftdir) begin
                        val = m_osr & msk;
                        m_osr = (n == 32) ? 32'd0 : (m_osr >> n);
                    end else begin
                        val = (n == 32) ? m_osr : (m_osr >> (32 - n));
                        m_osr = (n == 32) ? 32'd0 : (m_osr << n);
                    end
                    m_osrc = imin(m_osrc + n, 32);
                    case (sel)
                        0: m_pout = (m_pout & ~msk) | val;
                        1: m_x = val;
                        2: m_y = val;
                        4: m_pdir = (m_pdir & ~msk) | val;
                        default: ;
                    endcase
                end
                4: if (!ins[7]) begin
                    if (rx0 < 4) begin fsm_push = 1; pushed = m_isr; m_isr = 0; m_isrc = 0; end
                    else stall = ins[5];
                end else begin
                    if (tx0 > 0) begin fsm_pull = 1; m_osr = m_tx[0]; m_osrc = 0; end
                    else stall = ins[5];
                end
                5: begin
                    ok = 1;
                    case (int'(ins[2:0])) 0: val = gpio_input; 1: val = m_x; 2: val = m_y;
                        3: val = 0; 6: val = m_isr; 7: val = m_osr;
                        default: begin ok = 0; val = 0; end endcase
                    if (ok) case (sel) 0: m_pout = val; 1: m_x = val; 2: m_y = val; default: ; endcase
                end
                7: case (sel)
                    0: m_pout = {m_pout[31:5], ins[4:0]};
                    1: m_x = {27'd0, ins[4:0]};
                    2: m_y = {27'd0, ins[4:0]};
                    4: m_pdir = {m_pdir[31:5], ins[4:0]};
                    default: ;
                endcase
                default: ;
            endcase
            nxt = taken ? ins[4:0] : m_pc + 5'd1;
            if (!stall) begin
                if (dly == 0) m_pc = nxt;
                else begin m_delay = dly; m_pend = nxt; end
            end
        end
        if (fsm_pull) void'(m_tx.pop_front());
        if (push_en && tx0 < 4) m_tx.push_back(fifo_in);
        if (pop_en && rx0 > 0) void'(m_rx.pop_front());
        if (fsm_push) m_rx.push_back(pushed);
    endtask

    always @(posedge clk or negedge rst) begin
        if (!rst) model_reset();
        else      model_step();
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (rst) begin
            check("pc", {27'd0, pc}, {27'd0, m_pc});
            check("fifo_out", fifo_out, (m_rx.size() > 0) ? m_rx[0] : 32'd0);
            check("core_drive", core_drive, m_pdir);
            check("core_output", core_output, m_pout & m_pdir);
        end
    end

    // ---------------- stimulus helpers ----------------
    logic [15:0] prog[$];

    function automatic logic [15:0] enc(input logic [2:0] op, input logic [4:0] d, input logic [7:0] o);
        return {op, d, o};
    endfunction

    task automatic drive(input logic we, input logic [4:0] wa, input logic [15:0] wi,
                         input logic pu, input logic [31:0] fd, input logic po);
        write_en = we; write_addr = wa; instr_in = wi; push_en = pu; fifo_in = fd; pop_en = po;
        @(negedge clk);
        write_en = 1'b0; push_en = 1'b0; pop_en = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle(3);
        rst = 1'b1;
    endtask

    // Address 0 goes last so the engine (parked on JMP 0) starts cleanly
    task automatic load_prog();
        for (int i = prog.size() - 1; i >= 0; i--)
            drive(1'b1, 5'(i), prog[i], 1'b0, 32'd0, 1'b0);
    endtask

    function automatic logic [15:0] rand_instr();
        logic [4:0] d;
        d = ($urandom_range(0, 9) < 7) ? 5'd0 : 5'($urandom_range(1, 4));
        return {3'($urandom_range(0, 7)), d, 8'($urandom)};
    endfunction

    initial begin
        // Reset with no program
        @(negedge clk);
        do_reset();
        idle(4);
        check("rst_pc", {27'd0, pc}, 32'd0);
        check("rst_out", core_output, 32'd0);
        check("rst_drv", core_drive, 32'd0);
        check("rst_fifo", fifo_out, 32'd0);

        // SET PINDIRS / SET PINS / JMP self
        prog = '{16'hE09F, 16'hE015, 16'h0002};
        load_prog();
        idle(5);
        check("set_drv", core_drive, 32'h0000_001F);
        check("set_out", core_output, 32'h0000_0015);
        check("set_pc", {27'd0, pc}, 32'd2);

        // X-- loop, then X observed through full-width pins
        do_reset();
        drive(1'b0, 5'd0, 16'd0, 1'b1, 32'hFFFF_FFFF, 1'b0);
        prog = '{16'h80A0, 16'h6080, 16'hE023, 16'h0043, 16'hA001, 16'h0005};
        load_prog();
        idle(6);
        check("loop_pc_taken", {27'd0, pc}, 32'd3);
        idle(1);
        check("loop_pc_exit", {27'd0, pc}, 32'd4);
        idle(4);
        check("loop_x", core_output, 32'hFFFF_FFFF);
        check("loop_pc_end", {27'd0, pc}, 32'd5);

        // Blocking PULL stall, then OUT PINDIRS 8 / OUT PINS 8 shifting right
        do_reset();
        out_shiftdir = 1'b1;
        prog = '{16'h80A0, 16'h6088, 16'h80A0, 16'h6008, 16'h0004};
        load_prog();
        idle(5);
        check("pull_stall_pc", {27'd0, pc}, 32'd0);
        drive(1'b0, 5'd0, 16'd0, 1'b1, 32'h0000_00FF, 1'b0);
        idle(3);
        check("pull2_stall_pc", {27'd0, pc}, 32'd2);
        check("out_drv", core_drive, 32'h0000_00FF);
        drive(1'b0, 5'd0, 16'd0, 1'b1, 32'hA5A5_0003, 1'b0);
        idle(4);
        check("out_pins", core_output, 32'h0000_0003);
        check("out_pc", {27'd0, pc}, 32'd4);

        // SET X 7; IN X 4; PUSH block -> RX head 7, pop empties
        do_reset();
        prog = '{16'hE027, 16'h4024, 16'h8020, 16'h0003};
        load_prog();
        idle(4);
        check("push_fifo", fifo_out, 32'h0000_0007);
        drive(1'b0, 5'd0, 16'd0, 1'b0, 32'd0, 1'b1);
        check("pop_fifo", fifo_out, 32'd0);

        // Delay cycles hold pc; async reset mid-delay
        do_reset();
        prog = '{enc(3'b111, 5'd3, 8'h41), enc(3'b111, 5'd5, 8'h21), 16'h0002};
        load_prog();
        idle(1);
        check("dly_pc_e1", {27'd0, pc}, 32'd0);
        idle(2);
        check("dly_pc_e3", {27'd0, pc}, 32'd0);
        idle(1);
        check("dly_pc_e4", {27'd0, pc}, 32'd1);
        idle(2);
        check("dly_pc_held", {27'd0, pc}, 32'd1);
        #2 rst = 1'b0;
        #1 check("async_rst_pc", {27'd0, pc}, 32'd0);
        check("async_rst_drv", core_drive, 32'd0);
        idle(2);
        rst = 1'b1;

        // Random programs and traffic against the model
        for (int r = 0; r < 4; r++) begin
            do_reset();
            prog.delete();
            for (int i = 0; i < 32; i++) prog.push_back(rand_instr());
            load_prog();
            for (int c = 0; c < 600; c++) begin
                gpio_input   = $urandom;
                out_shiftdir = 1'($urandom_range(0, 1));
                drive(($urandom_range(0, 99) < 3), 5'($urandom), rand_instr(),
                      ($urandom_range(0, 1) == 1), $urandom, ($urandom_range(0, 9) < 4));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pio_engine.md
# pio_engine

Single-state-machine programmable I/O engine: a 32×16-bit instruction memory, one PIO-style execution FSM with TX/RX FIFOs, and a 4-slot output arbitrator that drives the chip GPIO output and output-enable buses. It sits between the host/SPI configuration path (instruction writes, FIFO push/pop) and the GPIO pads. FSM slots 1–3 of the arbitrator are tied to zero and reserved for future state machines.

## Interface
- No parameters.
- clk  input  1  clock; all state updates on its rising edge
- rst  input  1  asynchronous, active-low reset
- gpio_input  input  32  pad input values
- instr_in  input  16  instruction write data
- write_addr  input  5  instruction write address
- write_en  input  1  instruction write strobe
- push_en  input  1  push fifo_in into TX FIFO
- fifo_in  input  32  TX FIFO write data
- pop_en  input  1  pop RX FIFO head
- fifo_out  output  32  RX FIFO head (0 when empty)
- out_shiftdir  input  1  OSR shift: 1 = right (LSB first), 0 = left (MSB first)
- pc  output  5  current program counter
- core_output  output  32  arbitrated pad output values
- core_drive  output  32  arbitrated pad output enables

## Operation
- Instruction memory: 32 entries, synchronous write when write_en, combinational read at pc. Reset clears all entries to 0x0000 (JMP always 0).
- Encoding: [15:13] opcode, [12:8] delay cycles (no side-set), [7:0] operands. PC increments after each completed instruction, 31 wraps to 0.
- JMP (000): [7:5] cond, [4:0] target. Conds: 0 always, 1 X==0, 2 X!=0 then X--, 3 Y==0, 4 Y!=0 then Y--, 5 X!=Y, 6 gpio_input[0]==1, 7 OSR count<32. Decrement occurs even when not taken (post-test).
- IN (010): [7:5] src (0 PINS=gpio_input, 1 X, 2 Y, 3 NULL), [4:0] count (0=32). ISR shifts left, low count bits of src enter LSBs; ISR count saturates at 32.
- OUT (011): [7:5] dst (0 PINS, 1 X, 2 Y, 3 NULL, 4 PINDIRS), [4:0] count (0=32). Takes count bits from OSR per out_shiftdir (right: LSBs; left: MSBs), zero-fills, OSR count += count (saturate 32). PINS/PINDIRS write the low count bits of FSM output/drive, others unchanged; X/Y get zero-extended value.
- PUSH/PULL (100): bit7 0=PUSH, 1=PULL; bit5 block. PUSH: ISR → RX FIFO, ISR and its count cleared. PULL: TX head → OSR, OSR count = 0. Blocking and FIFO full (PUSH)/empty (PULL): stall, pc holds, retried each cycle. Non-blocking in that case: no-op.
- MOV (101): [7:5] dst (0 PINS, 1 X, 2 Y), [2:0] src (0 PINS, 1 X, 2 Y, 3 NULL, 6 ISR, 7 OSR); MOV to OSR/ISR unsupported.
- SET (111): [7:5] dst (0 PINS, 1 X, 2 Y, 4 PINDIRS), [4:0] data; PINS/PINDIRS write bits 4:0 only; X/Y zero-extended.
- WAIT, IRQ, undefined destinations/sources: NOP (still honour delay).
- FIFOs: 4 entries each. push_en when TX full: dropped. pop_en when RX empty: ignored. External push and FSM PULL on the same cycle both succeed (pull of previous head).
- Arbitrator: per bit, core_drive = OR of slot drives; core_output = output of highest-index slot whose drive bit is set, else 0. Combinational.

## Timing
- Reset (async assert): pc=0, X=Y=0, ISR=OSR=0, ISR count 0, OSR count 32, FIFOs empty, FSM output/drive 0, core_output=core_drive=0, fifo_out=0, delay counter 0.
- Each instruction executes in one cycle, then delay D adds D idle cycles (pc held); stalled cycles do not consume delay.
- Instruction written to the address currently executing: execution uses the old word that cycle.
- FIFO state and fifo_out update one cycle after push/pop; core_output reflects FSM pin writes the cycle after execution.

## Test plan
- Reset, no program -> pc stays 0, core_output=core_drive=0, fifo_out=0.
- Load SET PINDIRS 0x1F; SET PINS 0x15; JMP 2 -> core_drive=0x1F, core_output=0x15, pc holds at 2.
- Load SET X 3; JMP X-- 1 (addr1), then JMP 2 -> loop taken 3 times, X ends at 0xFFFFFFFF, pc reaches 2.
- PULL block with TX empty -> pc stalls; push 0xA5A5_0003 -> OSR loaded; OUT PINS 8 with out_shiftdir=1 and PINDIRS 0xFF -> core_output[7:0]=0x03.
- SET X 7; IN X 4; PUSH block -> fifo_out=0x7; pop -> fifo_out=0.
- SET Y 1 with delay 3 at addr0 -> pc advances to 1 only after 4 cycles; async reset mid-delay -> pc=0 immediately.
